// File: rtl/uart_rx_pkg.sv
// Shared UART RX/TX definitions: frame size limits, error flag layout and config helpers.
package uart_rx_pkg;

  localparam int unsigned UART_MIN_DATA_BITS = 5;

  typedef struct packed {
    logic parity_err;
    logic short_err;
  } rx_flags_t;

  // Force a requested frame width into [UART_MIN_DATA_BITS, max_bits].
  function automatic logic [3:0] clamp_data_bits(input logic [3:0] req,
                                                 input int unsigned max_bits);
    if (32'(req) < UART_MIN_DATA_BITS) return 4'(UART_MIN_DATA_BITS);
    if (32'(req) > max_bits) return 4'(max_bits);
    return req;
  endfunction

endpackage

// File: rtl/uart_rx_sync_fifo.sv
// Synchronous-reset FIFO with valid/ready pop, occupancy count and a drop-on-full overrun pulse.
module uart_rx_sync_fifo #(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CntW = $clog2(DEPTH + 1),
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_valid,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_ready,
  output logic             pop_valid,
  output logic [WIDTH-1:0] pop_data,
  output logic             overrun,
  output logic [CntW-1:0]  count
);

  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             overrun_q, overrun_d;
  logic             full, empty, do_pop, do_push;

  always_comb begin
    full    = (count_q == FullCnt);
    empty   = (count_q == '0);
    do_pop  = pop_ready && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    do_push = push_valid && (!full || do_pop);

    wr_d      = wr_q;
    rd_d      = rd_q;
    count_d   = count_q;
    overrun_d = push_valid && full && !do_pop;

    if (do_push) wr_d = (wr_q == LastPtr) ? '0 : wr_q + PtrW'(1);
    if (do_pop)  rd_d = (rd_q == LastPtr) ? '0 : rd_q + PtrW'(1);
    if (do_push && !do_pop)      count_d = count_q + CntW'(1);
    else if (do_pop && !do_push) count_d = count_q - CntW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q      <= '0;
      rd_q      <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_data;
  end

  assign pop_valid = !empty;
  assign pop_data  = empty ? '0 : mem_q[rd_q];
  assign overrun   = overrun_q;
  assign count     = count_q;

endmodule

// File: rtl/uart_rx_frame_assembler.sv
// UART RX frame assembler: places sampled data bits by index, tags errors, queues frames.
// Optional parity checking is compiled in with UART_RX_PARITY_CHECK_EN.
module uart_rx_frame_assembler
  import uart_rx_pkg::*;
#(
  parameter int unsigned MAX_DATA_BITS = 9,
  parameter int unsigned DEPTH         = 4,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sample_enable,
  input  logic                     bit_sample,
  input  logic                     is_data_bit,
  input  logic                     is_parity_bit,
  input  logic                     frame_complete,
  input  logic                     frame_abort,
  input  logic [3:0]               data_bits,
  input  logic                     lsb_first,
  input  logic                     parity_en,
  input  logic                     parity_odd,
  output logic [MAX_DATA_BITS-1:0] rx_data,
  output logic                     rx_parity_err,
  output logic                     rx_short_err,
  output logic                     rx_valid,
  input  logic                     rx_ready,
  output logic                     rx_overrun,
  output logic [CntW-1:0]          fifo_count
);

  localparam int unsigned EntryW = MAX_DATA_BITS + 2;

  typedef enum logic [0:0] {StIdle, StAssemble} state_e;

  state_e                   state_q, state_d;
  logic [3:0]               idx_q, idx_d, idx_new;
  logic [3:0]               n_q, n_d, n_cfg, n_eff, pos;
  logic                     lsb_q, lsb_d, lsb_eff;
  logic [MAX_DATA_BITS-1:0] asm_q, asm_d, asm_new;
  logic                     idle, data_stb, frame_end, wr_bit, push, parity_err;
  rx_flags_t                push_flags, head_flags;
  logic [EntryW-1:0]        head;

  assign idle      = (state_q == StIdle);
  assign data_stb  = sample_enable && is_data_bit;
  assign frame_end = frame_complete || frame_abort;
  assign push      = frame_complete && !frame_abort;

  always_comb begin
    // Config is taken live until the first data bit, then the latched copy rules.
    n_cfg   = clamp_data_bits(data_bits, MAX_DATA_BITS);
    n_eff   = idle ? n_cfg : n_q;
    lsb_eff = idle ? lsb_first : lsb_q;
    wr_bit  = data_stb && (idx_q < n_eff);
    pos     = lsb_eff ? idx_q : (n_eff - 4'd1 - idx_q);

    asm_new = asm_q;
    idx_new = idx_q;
    if (wr_bit) begin
      for (int unsigned i = 0; i < MAX_DATA_BITS; i++) begin
        if (4'(i) == pos) asm_new[i] = bit_sample;
      end
      idx_new = idx_q + 4'd1;
    end

    state_d = state_q;
    n_d     = n_q;
    lsb_d   = lsb_q;
    asm_d   = asm_new;
    idx_d   = idx_new;
    if (idle && data_stb) begin
      state_d = StAssemble;
      n_d     = n_cfg;
      lsb_d   = lsb_first;
    end
    if (frame_end) begin
      state_d = StIdle;
      asm_d   = '0;
      idx_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      n_q     <= 4'(UART_MIN_DATA_BITS);
      lsb_q   <= 1'b1;
      asm_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      lsb_q   <= lsb_d;
      asm_q   <= asm_d;
    end
  end

`ifdef UART_RX_PARITY_CHECK_EN
  logic pen_q, pen_d, podd_q, podd_d, pen_eff, podd_eff;
  logic par_seen_q, par_seen_d, par_err_q, par_err_d, par_stb, par_calc;

  always_comb begin
    pen_eff  = idle ? parity_en : pen_q;
    podd_eff = idle ? parity_odd : podd_q;
    par_stb  = sample_enable && is_parity_bit && pen_eff;
    par_calc = bit_sample ^ (^asm_new) ^ podd_eff;

    pen_d      = pen_q;
    podd_d     = podd_q;
    par_seen_d = par_seen_q;
    par_err_d  = par_err_q;
    if (idle && data_stb) begin
      pen_d  = parity_en;
      podd_d = parity_odd;
    end
    if (par_stb) begin
      par_seen_d = 1'b1;
      par_err_d  = par_calc;
    end
    // A parity-enabled frame committed without its parity bit counts as an error.
    parity_err = pen_eff && (par_stb ? par_calc : (par_seen_q ? par_err_q : 1'b1));
    if (frame_end) begin
      par_seen_d = 1'b0;
      par_err_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pen_q      <= 1'b0;
      podd_q     <= 1'b0;
      par_seen_q <= 1'b0;
      par_err_q  <= 1'b0;
    end else begin
      pen_q      <= pen_d;
      podd_q     <= podd_d;
      par_seen_q <= par_seen_d;
      par_err_q  <= par_err_d;
    end
  end
`else
  logic unused_parity;
  assign unused_parity = ^{is_parity_bit, parity_en, parity_odd};
  assign parity_err    = 1'b0;
`endif

  assign push_flags.parity_err = parity_err;
  assign push_flags.short_err  = (idx_new < n_eff);

  uart_rx_sync_fifo #(
    .WIDTH (EntryW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (push),
    .push_data  ({push_flags, asm_new}),
    .pop_ready  (rx_ready),
    .pop_valid  (rx_valid),
    .pop_data   (head),
    .overrun    (rx_overrun),
    .count      (fifo_count)
  );

  assign head_flags    = rx_flags_t'(head[EntryW-1:MAX_DATA_BITS]);
  assign rx_data       = head[MAX_DATA_BITS-1:0];
  assign rx_parity_err = head_flags.parity_err;
  assign rx_short_err  = head_flags.short_err;

endmodule

// File: tb/tb_uart_rx_frame_assembler.sv
// Scoreboard bench for uart_rx_frame_assembler: frames are modelled on send, compared on pop.
module tb_uart_rx_frame_assembler;

  localparam int unsigned MAXB  = 9;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNTW  = $clog2(DEPTH + 1);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            sample_enable = 1'b0, bit_sample = 1'b0, is_data_bit = 1'b0;
  logic            is_parity_bit = 1'b0, frame_complete = 1'b0, frame_abort = 1'b0;
  logic [3:0]      data_bits = 4'd8;
  logic            lsb_first = 1'b1, parity_en = 1'b0, parity_odd = 1'b0;
  logic [MAXB-1:0] rx_data;
  logic            rx_parity_err, rx_short_err, rx_valid, rx_overrun;
  logic            rx_ready = 1'b0;
  logic [CNTW-1:0] fifo_count;

  uart_rx_frame_assembler #(
    .MAX_DATA_BITS (MAXB),
    .DEPTH         (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sample_enable  (sample_enable),
    .bit_sample     (bit_sample),
    .is_data_bit    (is_data_bit),
    .is_parity_bit  (is_parity_bit),
    .frame_complete (frame_complete),
    .frame_abort    (frame_abort),
    .data_bits      (data_bits),
    .lsb_first      (lsb_first),
    .parity_en      (parity_en),
    .parity_odd     (parity_odd),
    .rx_data        (rx_data),
    .rx_parity_err  (rx_parity_err),
    .rx_short_err   (rx_short_err),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .rx_overrun     (rx_overrun),
    .fifo_count     (fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [MAXB-1:0] data;
    logic            perr;
    logic            serr;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   ovr_cnt  = 0;

  always @(negedge clk) if (rst_n && rx_overrun) ovr_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic par_model(input logic pen, input int par_mode, input logic pbit,
                                     input logic podd, input logic [MAXB-1:0] d);
`ifdef UART_RX_PARITY_CHECK_EN
    if (!pen) return 1'b0;
    if (par_mode == 0) return 1'b1;
    return pbit ^ (^d) ^ podd;
`else
    return 1'b0 & pen & pbit & podd & (^d) & (par_mode != 0);
`endif
  endfunction

  // Drives one frame at negedges; config is scrambled after the first strobe to prove it latched.
  task automatic send_frame(input int nstrobes, input logic [15:0] bits, input int cfg_bits,
                            input logic lsb, input logic pen, input logic podd,
                            input int par_mode, input logic pbit, input logic merge,
                            input logic abort_too, input logic ready_on_commit,
                            input logic expect_push);
    int   n;
    exp_t e;
    exp_t h;
    n = (cfg_bits < 5) ? 5 : (cfg_bits > int'(MAXB)) ? int'(MAXB) : cfg_bits;
    e.data = '0;
    for (int k = 0; k < nstrobes && k < n; k++) begin
      if (lsb) e.data[k] = bits[k];
      else     e.data[n-1-k] = bits[k];
    end
    e.serr = (nstrobes < n);
    e.perr = par_model(pen, par_mode, pbit, podd, e.data);

    data_bits = 4'(cfg_bits); lsb_first = lsb; parity_en = pen; parity_odd = podd;
    for (int k = 0; k < nstrobes; k++) begin
      sample_enable = 1'b1; is_data_bit = 1'b1; bit_sample = bits[k];
      if (merge && k == nstrobes - 1) frame_complete = 1'b1;
      tick();
      sample_enable = 1'b0; is_data_bit = 1'b0; frame_complete = 1'b0;
      if (k == 0) begin
        data_bits = ~data_bits; lsb_first = ~lsb; parity_en = ~pen; parity_odd = ~podd;
      end
    end
    if (par_mode != 0) begin
      sample_enable = 1'b1; is_parity_bit = 1'b1; bit_sample = pbit;
      tick();
      sample_enable = 1'b0; is_parity_bit = 1'b0;
    end
    if (!merge) begin
      frame_complete = 1'b1;
      frame_abort = abort_too;
      if (ready_on_commit) begin
        rx_ready = 1'b1;
        if (sb.size() > 0) begin
          h = sb.pop_front();
          check("pop_on_commit_data", 32'(rx_data), 32'(h.data));
        end else check("pop_on_commit_sb", 0, 1);
      end
      tick();
      frame_complete = 1'b0; frame_abort = 1'b0; rx_ready = 1'b0;
    end
    if (expect_push) sb.push_back(e);
  endtask

  task automatic drain_check(input int n);
    int   guard;
    exp_t e;
    rx_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      guard = 0;
      while (!rx_valid && guard < 20) begin tick(); guard++; end
      if (!rx_valid) begin check("drain_valid_timeout", 0, 1); break; end
      if (sb.size() == 0) begin check("drain_sb_empty", 1, 0); break; end
      e = sb.pop_front();
      check("rx_data", 32'(rx_data), 32'(e.data));
      check("rx_parity_err", 32'(rx_parity_err), 32'(e.perr));
      check("rx_short_err", 32'(rx_short_err), 32'(e.serr));
      tick();
    end
    rx_ready = 1'b0;
    check("drained_count", 32'(fifo_count), 32'(sb.size()));
  endtask

  initial begin
    int base;
    logic [15:0] rb;
    logic exp_p;

    repeat (3) tick();
    check("rst_valid", 32'(rx_valid), 0);
    check("rst_count", 32'(fifo_count), 0);
    check("rst_data", 32'(rx_data), 0);
    check("rst_errs", 32'({rx_parity_err, rx_short_err, rx_overrun}), 0);
    rst_n = 1'b1;
    tick();

    // 8N1 LSB-first 1,0,1,0,0,1,1,0
    send_frame(8, 16'h0065, 8, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("lat_valid", 32'(rx_valid), 1);
    check("lsb_data_const", 32'(rx_data), 32'h065);
    drain_check(1);

    send_frame(8, 16'h0065, 8, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("msb_data_const", 32'(rx_data), 32'h0A6);
    drain_check(1);

    send_frame(7, 16'h007F, 5, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("five_bit_const", 32'(rx_data), 32'h01F);
    drain_check(1);

    send_frame(6, 16'h003F, 8, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("short_flag", 32'(rx_short_err), 1);
    send_frame(8, 16'h00C3, 8, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    send_frame(9, 16'h01A5, 12, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(5, 16'h0015, 2, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drain_check(4);

    // Pure abort and abort coincident with complete: no push.
    sample_enable = 1'b1; is_data_bit = 1'b1; bit_sample = 1'b1;
    repeat (3) tick();
    sample_enable = 1'b0; is_data_bit = 1'b0; frame_abort = 1'b1;
    tick();
    frame_abort = 1'b0;
    tick();
    check("abort_count", 32'(fifo_count), 0);
    send_frame(8, 16'h00FF, 8, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    check("abort_win_count", 32'(fifo_count), 0);
    // Fresh frame after abort must not contain stale bits.
    send_frame(8, 16'h0001, 8, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drain_check(1);

    // Overrun: DEPTH+1 commits with the consumer stalled.
    base = ovr_cnt;
    for (int f = 0; f <= int'(DEPTH); f++) begin
      rb = 16'($urandom_range(0, 255));
      send_frame(8, rb, 8, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, (f < int'(DEPTH)));
    end
    tick();
    check("full_count", 32'(fifo_count), DEPTH);
    check("overrun_pulses", 32'(ovr_cnt - base), 1);
    check("held_data", 32'(rx_data), 32'(sb[0].data));
    // Full + pop + push in the same cycle.
    base = ovr_cnt;
    send_frame(8, 16'h005A, 8, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    check("pushpop_count", 32'(fifo_count), DEPTH);
    check("pushpop_no_overrun", 32'(ovr_cnt - base), 0);
    drain_check(int'(DEPTH));

    // 8E1, data 0x07: parity bit 0 is wrong, 1 is right; then a missing parity bit.
    send_frame(8, 16'h0007, 8, 1'b1, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef UART_RX_PARITY_CHECK_EN
    exp_p = 1'b1;
`else
    exp_p = 1'b0;
`endif
    check("parity_bad_const", 32'(rx_parity_err), 32'(exp_p));
    send_frame(8, 16'h0007, 8, 1'b1, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(7, 16'h0055, 7, 1'b0, 1'b1, 1'b1, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8, 16'h0033, 8, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drain_check(4);

    // Reset mid-frame discards the partial frame.
    send_frame(8, 16'h0011, 8, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    sample_enable = 1'b1; is_data_bit = 1'b1; bit_sample = 1'b1;
    repeat (3) tick();
    sample_enable = 1'b0; is_data_bit = 1'b0; rst_n = 1'b0;
    sb.delete();
    tick();
    rst_n = 1'b1;
    check("midreset_count", 32'(fifo_count), 0);
    check("midreset_valid", 32'(rx_valid), 0);
    send_frame(8, 16'h0080, 8, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drain_check(1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
